// File: rtl/vec_exec_pkg.sv
// Shared types and saturation limits for the serial vector execution engine.
// Pure declarations: no latency, no flow control.
package vec_exec_pkg;

  typedef enum logic [1:0] {
    VADD = 2'b00,
    VDOT = 2'b01,
    SMUL = 2'b10,
    RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  // Limits are returned 64 bits wide; callers keep the low w bits.
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    return ~sat_pos(w);
  endfunction

endpackage

// File: rtl/vec_elem_alu.sv
// Combinational per-element VADD/SMUL/VDOT datapath with overflow detection; zero latency, no backpressure.
// VEC_SAT_EN defined clamps every overflowing result instead of wrapping.
module vec_elem_alu
  import vec_exec_pkg::*;
#(
  parameter int W = 16
) (
  input  op_t          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] acc_i,
  output logic [W-1:0] result_o,
  output logic [W-1:0] next_acc_o,
  output logic         ovf_o
);

`ifdef VEC_SAT_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_pos(W));
  localparam logic [W-1:0] SAT_NEG = W'(sat_neg(W));
`endif

  logic [W-1:0]   sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_w;
  logic [W-1:0]   acc_sum;
  logic           sum_ovf;
  logic           prod_ovf;
  logic           acc_ovf;

  always_comb begin
    sum     = a_i + b_i;
    sum_ovf = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);

    // Sign-extended operands make the unsigned 2W-bit product the signed one.
    prod     = {{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i};
    prod_ovf = !(&prod[2*W-1:W-1]) && (|prod[2*W-1:W-1]);
    prod_w   = prod[W-1:0];
`ifdef VEC_SAT_EN
    if (sum_ovf)  sum    = a_i[W-1] ? SAT_NEG : SAT_POS;
    if (prod_ovf) prod_w = prod[2*W-1] ? SAT_NEG : SAT_POS;
`endif

    acc_sum = acc_i + prod_w;
    acc_ovf = (acc_i[W-1] == prod_w[W-1]) && (acc_sum[W-1] != acc_i[W-1]);
`ifdef VEC_SAT_EN
    if (acc_ovf) acc_sum = acc_i[W-1] ? SAT_NEG : SAT_POS;
`endif

    result_o   = '0;
    next_acc_o = acc_i;
    ovf_o      = 1'b0;
    case (op_i)
      VADD: begin
        result_o = sum;
        ovf_o    = sum_ovf;
      end
      SMUL: begin
        result_o = prod_w;
        ovf_o    = prod_ovf;
      end
      VDOT: begin
        result_o   = acc_sum;
        next_acc_o = acc_sum;
        ovf_o      = prod_ovf | acc_ovf;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Serial vector engine: one element per cycle, N+2 cycles per operation, Done pulse with sticky V; no backpressure.
// VEC_SAT_EN (in vec_elem_alu) selects saturating instead of wrapping arithmetic.
module vec_exec_unit
  import vec_exec_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk1_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [W-1:0]     scalar_i,
  output logic [IDX_W-1:0] elem_idx_o,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [W-1:0]     wr_data_o,
  output logic             s_wr_o,
  output logic [W-1:0]     s_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             v_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q;
  op_t              op_q;
  logic [W-1:0]     scalar_q;
  logic [IDX_W-1:0] cnt_q;
  logic [W-1:0]     acc_q;
  logic             wr_en_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [W-1:0]     wr_data_q;
  logic             s_wr_q;
  logic [W-1:0]     s_out_q;
  logic             busy_q;
  logic             done_q;
  logic             v_q;

  logic [W-1:0]     wr_data_d;
  logic [W-1:0]     acc_d;
  logic             ovf_d;

  // The second operand is the latched scalar for SMUL, else source 2.
  vec_elem_alu #(.W(W)) u_alu (
    .op_i       (op_q),
    .a_i        (a_i),
    .b_i        ((op_q == SMUL) ? scalar_q : b_i),
    .acc_i      (acc_q),
    .result_o   (wr_data_d),
    .next_acc_o (acc_d),
    .ovf_o      (ovf_d)
  );

  always_ff @(posedge clk1_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      op_q      <= VADD;
      scalar_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      s_wr_q    <= 1'b0;
      s_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          s_wr_q  <= 1'b0;
          wr_en_q <= 1'b0;
          if (start_i) begin
            op_q     <= op_t'(op_i);
            scalar_q <= scalar_i;
            v_q      <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            // A reserved op skips RUN and completes in the very next cycle.
            if (op_t'(op_i) == RSVD) begin
              state_q <= DRAIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          v_q      <= v_q | ovf_d;
          wr_en_q  <= (op_q != VDOT);
          wr_idx_q <= cnt_q;
          if (op_q != VDOT) wr_data_q <= wr_data_d;
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            state_q <= DRAIN;
            done_q  <= 1'b1;
            s_wr_q  <= (op_q == VDOT);
            if (op_q == VDOT) s_out_q <= acc_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
          s_wr_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign elem_idx_o = cnt_q;
  assign wr_en_o    = wr_en_q;
  assign wr_idx_o   = wr_idx_q;
  assign wr_data_o  = wr_data_q;
  assign s_wr_o     = s_wr_q;
  assign s_out_o    = s_out_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign v_o        = v_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed table-driven bench for vec_exec_unit (W=16, N=16), plus reset-abort and held-Start sequences.
// Expected saturated values apply when VEC_SAT_EN is defined for the build.
module tb_vec_exec_unit;
  import vec_exec_pkg::*;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int NV = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  scalar;
  logic [IW-1:0] elem_idx;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic          s_wr;
  logic [W-1:0]  s_out;
  logic          busy;
  logic          done;
  logic          v;

  typedef struct {
    op_t                  op;
    logic [W-1:0]         scalar;
    logic [N-1:0][W-1:0]  a;
    logic [N-1:0][W-1:0]  b;
    logic [N-1:0][W-1:0]  exp;
    logic [W-1:0]         exp_sout;
    logic                 exp_v;
  } vec_t;

  vec_t                vecs[NV];
  logic [N-1:0][W-1:0] cur_a;
  logic [N-1:0][W-1:0] cur_b;
  int                  n_chk;
  int                  n_fail;

  assign a_in = cur_a[elem_idx];
  assign b_in = cur_b[elem_idx];

  vec_exec_unit #(.W(W), .N(N), .IDX_W(IW)) dut (
    .clk1_i     (clk),
    .reset_i    (reset),
    .start_i    (start),
    .op_i       (op),
    .scalar_i   (scalar),
    .elem_idx_o (elem_idx),
    .a_i        (a_in),
    .b_i        (b_in),
    .wr_en_o    (wr_en),
    .wr_idx_o   (wr_idx),
    .wr_data_o  (wr_data),
    .s_wr_o     (s_wr),
    .s_out_o    (s_out),
    .busy_o     (busy),
    .done_o     (done),
    .v_o        (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues vector t and checks every output from cycle 1 through the first idle cycle.
  task automatic run_vec(input int t, input bit hold);
    int done_cyc;
    bit writes;
    op_t vop;
    vop    = vecs[t].op;
    cur_a  = vecs[t].a;
    cur_b  = vecs[t].b;
    @(negedge clk);
    op     = vop;
    scalar = vecs[t].scalar;
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    done_cyc = (vop == RSVD) ? 1 : N + 1;
    writes   = (vop == VADD) || (vop == SMUL);
    for (int k = 1; k <= done_cyc + 1; k++) begin
      @(negedge clk);
      check($sformatf("v%0d c%0d busy", t, k), 32'(busy), 32'(k <= done_cyc));
      check($sformatf("v%0d c%0d done", t, k), 32'(done), 32'(k == done_cyc));
      check($sformatf("v%0d c%0d swr", t, k), 32'(s_wr), 32'((k == done_cyc) && (vop == VDOT)));
      check($sformatf("v%0d c%0d wren", t, k), 32'(wr_en), 32'(writes && (k >= 2) && (k <= N + 1)));
      if (vop != RSVD && k <= N)
        check($sformatf("v%0d c%0d elemidx", t, k), 32'(elem_idx), 32'(k - 1));
      if (writes && k >= 2 && k <= N + 1) begin
        check($sformatf("v%0d c%0d wridx", t, k), 32'(wr_idx), 32'(k - 2));
        check($sformatf("v%0d c%0d wrdata", t, k), 32'(wr_data), 32'(vecs[t].exp[k-2]));
      end
      if (k == done_cyc) begin
        check($sformatf("v%0d v", t), 32'(v), 32'(vecs[t].exp_v));
        if (vop == VDOT) check($sformatf("v%0d sout", t), 32'(s_out), 32'(vecs[t].exp_sout));
      end
    end
  endtask

  initial begin
    int cyc;
    int n_done;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    scalar = '0;
    cur_a  = '0;
    cur_b  = '0;

    for (int t = 0; t < NV; t++) begin
      vecs[t].op       = VADD;
      vecs[t].scalar   = '0;
      vecs[t].a        = '0;
      vecs[t].b        = '0;
      vecs[t].exp      = '0;
      vecs[t].exp_sout = '0;
      vecs[t].exp_v    = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      vecs[0].a[i]   = 16'(i);
      vecs[0].b[i]   = 16'(2 * i);
      vecs[0].exp[i] = 16'(3 * i);
      vecs[2].a[i]   = 16'(i);
      vecs[2].b[i]   = 16'hFFFF;
      vecs[2].exp[i] = 16'(3 * i);
      vecs[3].b[i]   = 16'h1234;
      vecs[5].a[i]   = 16'd2;
      vecs[5].b[i]   = 16'd2;
      vecs[6].a[i]   = 16'hFFFD;
      vecs[6].b[i]   = 16'd5;
    end
    vecs[1].a[5]  = 16'h7FFF;
    vecs[1].b[5]  = 16'h0001;
    vecs[1].exp_v = 1'b1;
    vecs[2].op     = SMUL;
    vecs[2].scalar = 16'd3;
    vecs[3].op     = SMUL;
    vecs[3].scalar = 16'h0100;
    vecs[3].a[0]   = 16'h0100;
    vecs[3].exp_v  = 1'b1;
    vecs[4].op     = RSVD;
    vecs[5].op       = VDOT;
    vecs[5].exp_sout = 16'h0040;
    vecs[6].op       = VDOT;
    vecs[6].exp_sout = 16'hFF10;
    vecs[7].op       = VDOT;
    vecs[7].a[0]     = 16'h7FFF;
    vecs[7].b[0]     = 16'h7FFF;
    vecs[7].exp_v    = 1'b1;
`ifdef VEC_SAT_EN
    vecs[1].exp[5]   = 16'h7FFF;
    vecs[3].exp[0]   = 16'h7FFF;
    vecs[7].exp_sout = 16'h7FFF;
`else
    vecs[1].exp[5]   = 16'h8000;
    vecs[3].exp[0]   = 16'h0000;
    vecs[7].exp_sout = 16'h0001;
`endif

    repeat (3) @(negedge clk);
    check("rst elemidx", 32'(elem_idx), 32'd0);
    check("rst wren", 32'(wr_en), 32'd0);
    check("rst wridx", 32'(wr_idx), 32'd0);
    check("rst wrdata", 32'(wr_data), 32'd0);
    check("rst swr", 32'(s_wr), 32'd0);
    check("rst sout", 32'(s_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst v", 32'(v), 32'd0);
    reset = 1'b0;

    for (int t = 0; t < NV; t++) run_vec(t, 1'b0);

    // Abort a VADD with reset in cycle 6.
    cur_a = vecs[0].a;
    cur_b = vecs[0].b;
    @(negedge clk);
    op    = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort c6 wridx", 32'(wr_idx), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort wren", 32'(wr_en), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort elemidx", 32'(elem_idx), 32'd0);
    reset  = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || wr_en) n_done++;
    end
    check("abort no late done/write", 32'(n_done), 32'd0);
    run_vec(0, 1'b0);

    // Start held high: the second operation is accepted at the end of cycle N+2.
    run_vec(0, 1'b1);
    @(negedge clk);
    check("hold second busy", 32'(busy), 32'd1);
    check("hold second elemidx", 32'(elem_idx), 32'd0);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("hold second done", 32'(done), 32'd1);
    check("hold second done cycle", 32'(cyc), 32'(N));
    @(negedge clk);
    check("hold idle after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_exec_unit.md
# vec_exec_unit

Parametrised serial vector execution engine for the CVP vector datapath. It is the successor to the fixed 16-lane, 16-bit VADD/VDOT/SMUL units. It streams one element per cycle from two vector register read ports, computes VADD, VDOT or SMUL on signed W-bit elements, and writes results back through an element write port or a scalar write port. The controller issues a Start pulse and waits for Done, which carries a sticky overflow flag.

## Interface
- W, default 16: element width in bits (≥4).
- N, default 16: vector length in elements (≥2).
- IDX_W, default $clog2(N): element index width.
- Clk1 in 1: single clock; all state updates on its rising edge.
- Reset in 1: synchronous, active-high reset.
- Start in 1: operation request; sampled only in IDLE.
- Op in 2: 00 VADD, 01 VDOT, 10 SMUL, 11 reserved.
- Scalar in W: SMUL multiplier; latched on Start acceptance.
- ElemIdx out IDX_W: read index for both vector sources.
- A in W: source-1 element at ElemIdx, valid the same cycle.
- B in W: source-2 element at ElemIdx, valid the same cycle. Ignored for SMUL.
- WrEn out 1: vector element write strobe.
- WrIdx out IDX_W: vector element write index.
- WrData out W: vector element write data.
- SWr out 1: scalar write strobe (VDOT only).
- SOut out W: VDOT result.
- Busy out 1: high while not IDLE.
- Done out 1: one-cycle completion pulse.
- V out 1: sticky overflow flag for the last operation.

## Operation
- States are IDLE, RUN and DRAIN. State and all outputs are registered.
- Start in IDLE latches Op and Scalar, clears V, clears the counter and accumulator, then moves to RUN. Start outside IDLE is ignored.
- RUN: ElemIdx = counter. A and B are registered each cycle, and the counter increments. After index N-1, move to DRAIN.
- DRAIN: lasts one cycle. It emits the final result, pulses Done, then returns to IDLE.
- Op 11 goes IDLE→DRAIN directly: Done pulses, no WrEn, no SWr, V = 0.
- VADD: WrData = A+B.
  - Overflow when A and B have the same sign and the sum sign differs.
- SMUL: WrData = low W bits of Scalar×A, computed as a signed 2W-bit product.
  - Overflow when the upper W+1 product bits are not all equal.
- VDOT: acc += A×B, with the product reduced to W bits as in SMUL.
  - Overflow on any product overflow or on signed overflow of the accumulator add.
  - No element writes. In DRAIN, SWr = 1 and SOut = acc.
- V ORs every overflow of the current operation. It is final in the Done cycle and holds until the next accepted Start.
- Reset at any point forces IDLE and clears the counter, the accumulator and all outputs. An aborted operation produces no Done and no further writes.

## Timing
- Reset values: ElemIdx, WrEn, WrIdx, WrData, SWr, SOut, Busy, Done and V are all 0.
- Cycle k means the cycle after the k-th edge following the edge that sampled Start.
- RUN occupies cycles 1..N, with ElemIdx = k-1.
- Element i is written in cycle i+2: WrEn = 1, WrIdx = i. Writes therefore occur in cycles 2..N+1, with no gaps.
- DRAIN is cycle N+1: the last write, Done, and SWr (VDOT) all coincide.
- Busy is high in cycles 1..N+1.
- The earliest next Start is sampled in cycle N+2, giving a throughput of one operation per N+2 cycles.
- For Op 11, Done and Busy are both high in cycle 1 only.

## Configuration
- VEC_SAT_EN defined: every overflowing result clamps to 2^(W-1)-1 for positive overflow or -2^(W-1) for negative overflow.
  - This covers VADD sums, SMUL products, VDOT products and the VDOT accumulator.
  - The VDOT accumulator continues from the clamped value.
  - V is still set.
- VEC_SAT_EN undefined: all results wrap modulo 2^W. V behaviour is identical.

## Structure
- Package vec_exec_pkg contains:
  - The op_t enum: VADD, VDOT, SMUL, RSVD.
  - The state_t enum: IDLE, RUN, DRAIN.
  - Localparams for the saturation limits as functions of W.
- Sub-module vec_elem_alu is combinational. It takes op, A, B/Scalar and acc, and returns result, next_acc and ovf.
  - Saturation logic lives inside it, under VEC_SAT_EN.
- Top level contains the FSM, counter, operand and write-back registers, accumulator and sticky V.

## Test plan
All scenarios use W=16, N=16.
- VADD, A[i]=i, B[i]=2i: WrData=3i at WrIdx=i in cycles 2..17; Done in cycle 17; V=0; SWr never asserts.
- VADD, A[5]=0x7FFF, B[5]=0x0001, other elements 0: V=1 at Done.
  - Without VEC_SAT_EN: WrData[5]=0x8000.
  - With VEC_SAT_EN: WrData[5]=0x7FFF.
- SMUL, Scalar=3, A[i]=i: WrData=3i, V=0.
- SMUL, Scalar=0x0100, A[0]=0x0100: V=1.
  - Without VEC_SAT_EN: WrData[0]=0x0000.
  - With VEC_SAT_EN: WrData[0]=0x7FFF.
- VDOT, A[i]=B[i]=2: SOut=0x0040 with SWr and Done in cycle 17; WrEn never asserts; V=0.
- Reset asserted in cycle 6 of a VADD: the next cycle has Busy=0, WrEn=0 and no Done. A following VADD completes normally.
- Start held high for the whole of a VADD: exactly one operation runs, and the next is accepted in cycle 18.
- Op=11: Done=1 in cycle 1, V=0, no WrEn or SWr.
